// File: rtl/axi_read_arbiter.sv
// N-port AXI3 read master: arbitrates client reads onto one AR/R pair, one transaction in flight.
// Optional AXI_RD_RR_EN selects round-robin grant; otherwise fixed priority with port 0 highest.
module axi_read_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PIDX_W    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*4-1:0]    req_len,
    output logic [NUM_PORTS-1:0]      req_ready,
    output logic [NUM_PORTS-1:0]      resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_last,
    output logic                      resp_err,
    input  logic [NUM_PORTS-1:0]      resp_ready,
    output logic [3:0]                arid,
    output logic [ADDR_W-1:0]         araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [1:0]                arlock,
    output logic [3:0]                arcache,
    output logic [2:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [3:0]                rid,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_araddr;
    logic [3:0]          r_len;
    logic [3:0]          r_cnt;
    logic [PIDX_W-1:0]   r_grant;
    logic [PIDX_W-1:0]   w_win;
    logic                w_any;
    logic                w_beat;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [3:0]          w_sel_len;

    // kseg0/kseg1 (top bits 100/101) fold onto the physical low 512 MB
    function automatic logic [ADDR_W-1:0] unmap(input logic [ADDR_W-1:0] a);
        if (a[ADDR_W-1 -: 2] == 2'b10)
            return {3'b000, a[ADDR_W-4:0]};
        return a;
    endfunction

`ifdef AXI_RD_RR_EN
    logic [PIDX_W-1:0]   r_last;
    logic                w_found;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && req_valid[(int'(r_last) + 1 + k) % NUM_PORTS]) begin
                w_found = 1'b1;
                w_win   = PIDX_W'((int'(r_last) + 1 + k) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last <= '0;
        else if (r_state == S_IDLE && w_any)
            r_last <= w_win;
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (req_valid[k]) w_win = PIDX_W'(k);
    end
`endif

    assign w_any      = |req_valid;
    assign w_sel_addr = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_sel_len  = req_len[int'(w_win)*4 +: 4];
    assign w_beat     = rvalid & rready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any)            w_next = S_ADDR;
            S_ADDR: if (arready)          w_next = S_DATA;
            S_DATA: if (w_beat && rlast)  w_next = S_IDLE;
            default:                      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_araddr <= '0;
            r_len    <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_araddr <= unmap(w_sel_addr);
                    r_len    <= w_sel_len;
                    r_grant  <= w_win;
                end
                S_ADDR: if (arready) r_cnt <= '0;
                S_DATA: if (w_beat)  r_cnt <= r_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        resp_last  = 1'b0;
        resp_err   = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (r_state)
            // the grant pulse is combinational so the client sees it in the capture cycle
            S_IDLE: if (w_any && reset) req_ready[w_win] = 1'b1;
            S_ADDR: arvalid = 1'b1;
            S_DATA: begin
                rready              = resp_ready[r_grant];
                resp_valid[r_grant] = rvalid;
                resp_data           = rdata;
                resp_last           = rvalid & rlast;
                resp_err            = rvalid & ((rresp != 2'b00) || (rid != arid) ||
                                                (rlast != (r_cnt == r_len)));
            end
            default: ;
        endcase
    end

    assign arid    = 4'(r_grant);
    assign araddr  = r_araddr;
    assign arlen   = r_len;
    assign arsize  = 3'($clog2(DATA_W / 8));
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b001;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: stimulus pushes expected AR/R events into queues,
// an independent monitor pops and compares them on each handshake.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_last, resp_err;
    logic [1:0]  resp_ready;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi_read_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PIDX_W(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .resp_err(resp_err), .resp_ready(resp_ready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] id; logic [3:0] len; } ar_t;
    typedef struct { int port; logic [31:0] data; logic last; logic err; } beat_t;

    ar_t   ar_q[$];
    beat_t r_q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    tb_last  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got none expected event", name);
    endtask

    // Monitor: compare every AR and R handshake against the scoreboard queues
    initial begin
        ar_t   ea;
        beat_t eb;
        forever begin
            @(negedge clk);
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL ar_unexpected: got addr %0h expected no AR", araddr);
                end else begin
                    ea = ar_q.pop_front();
                    chk("araddr", araddr, ea.addr);
                    chk("arid", arid, ea.id);
                    chk("arlen", arlen, ea.len);
                    chk("ar_consts", {arsize, arburst, arlock, arcache, arprot},
                        {3'd2, 2'b01, 2'b00, 4'h0, 3'b001});
                end
            end
            if (|(resp_valid & resp_ready)) begin
                if (r_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL beat_unexpected: got data %0h expected no beat", resp_data);
                end else begin
                    eb = r_q.pop_front();
                    chk("resp_port", resp_valid, 64'(1) << eb.port);
                    chk("resp_data", resp_data, eb.data);
                    chk("resp_last", resp_last, eb.last);
                    chk("resp_err", resp_err, eb.err);
                    chk("rready", rready, 1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic req(input int p, input logic [31:0] a, input logic [3:0] l);
        req_addr[p*32 +: 32] = a;
        req_len[p*4 +: 4]    = l;
        req_valid[p]         = 1'b1;
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [3:0] id, input logic [3:0] l);
        ar_t e;
        e.addr = a; e.id = id; e.len = l;
        ar_q.push_back(e);
    endtask

    task automatic push_beat(input int p, input logic [31:0] d, input logic last, input logic err);
        beat_t e;
        e.port = p; e.data = d; e.last = last; e.err = err;
        r_q.push_back(e);
    endtask

    task automatic wait_grant(input int p);
        logic [1:0] seen;
        int k;
        seen = '0;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready != 2'b00) break;
        end
        if (k == 50) fail("grant_timeout");
        else begin
            seen = req_ready;
            chk("grant_port", req_ready, 64'(1) << p);
            tb_last = p;
        end
        @(posedge clk); #1;
        req_valid = req_valid & ~seen;
    endtask

    task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic last,
                             input logic [1:0] resp);
        int k;
        rid = id; rdata = d; rlast = last; rresp = resp; rvalid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rready) break;
        end
        if (k == 50) fail("rready_timeout");
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        int first, second;
        reset = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
        resp_ready = 2'b11; arready = 1'b1;
        rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {arvalid, rready, req_ready, resp_valid, resp_last, resp_err},
            '0);
        chk("rst_araddr", araddr, 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: single kseg1 fetch on port 1
        push_ar(32'h1FC00000, 4'd1, 4'd0);
        push_beat(1, 32'h24080001, 1'b1, 1'b0);
        req(1, 32'hBFC00000, 4'd0);
        wait_grant(1);
        send_beat(4'd1, 32'h24080001, 1'b1, 2'b00);
        tick();

        // 2: simultaneous requests
`ifdef AXI_RD_RR_EN
        first = (tb_last + 1) % 2;
`else
        first = 0;
`endif
        second = 1 - first;
        if (first == 0) begin
            push_ar(32'h00001000, 4'd0, 4'd0); push_beat(0, 32'hA0A0A0A0, 1'b1, 1'b0);
            push_ar(32'h1FC00004, 4'd1, 4'd0); push_beat(1, 32'hB1B1B1B1, 1'b1, 1'b0);
        end else begin
            push_ar(32'h1FC00004, 4'd1, 4'd0); push_beat(1, 32'hB1B1B1B1, 1'b1, 1'b0);
            push_ar(32'h00001000, 4'd0, 4'd0); push_beat(0, 32'hA0A0A0A0, 1'b1, 1'b0);
        end
        req(0, 32'h80001000, 4'd0);
        req(1, 32'hBFC00004, 4'd0);
        wait_grant(first);
        send_beat(4'(first), first == 0 ? 32'hA0A0A0A0 : 32'hB1B1B1B1, 1'b1, 2'b00);
        wait_grant(second);
        send_beat(4'(second), second == 0 ? 32'hA0A0A0A0 : 32'hB1B1B1B1, 1'b1, 2'b00);
        tick();

        // 3: 4-beat burst, AR stalled 2 cycles, consumer stalls beat 2 for 2 cycles
        arready = 1'b0;
        push_ar(32'h00002000, 4'd0, 4'd3);
        push_beat(0, 32'h11110000, 1'b0, 1'b0);
        push_beat(0, 32'h11110001, 1'b0, 1'b0);
        push_beat(0, 32'h11110002, 1'b0, 1'b0);
        push_beat(0, 32'h11110003, 1'b1, 1'b0);
        req(0, 32'h00002000, 4'd3);
        wait_grant(0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, 32'h00002000);
            tick();
        end
        arready = 1'b1;
        send_beat(4'd0, 32'h11110000, 1'b0, 2'b00);
        resp_ready[0] = 1'b0;
        rid = 4'd0; rdata = 32'h11110001; rlast = 1'b0; rresp = 2'b00; rvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_rready", rready, 0);
            chk("stall_resp_valid", resp_valid, 2'b01);
            tick();
        end
        resp_ready[0] = 1'b1;
        send_beat(4'd0, 32'h11110001, 1'b0, 2'b00);
        send_beat(4'd0, 32'h11110002, 1'b0, 2'b00);
        send_beat(4'd0, 32'h11110003, 1'b1, 2'b00);
        tick();

        // 4: early rlast on beat 2 of a len=3 burst
        push_ar(32'h00004000, 4'd1, 4'd3);
        push_beat(1, 32'h22220000, 1'b0, 1'b0);
        push_beat(1, 32'h22220001, 1'b1, 1'b1);
        req(1, 32'h80004000, 4'd3);
        wait_grant(1);
        send_beat(4'd1, 32'h22220000, 1'b0, 2'b00);
        send_beat(4'd1, 32'h22220001, 1'b1, 2'b00);
        tick();

        // 5: SLVERR on a single beat, then an rid mismatch
        push_ar(32'h00000010, 4'd0, 4'd0);
        push_beat(0, 32'h33333333, 1'b1, 1'b1);
        req(0, 32'hA0000010, 4'd0);
        wait_grant(0);
        send_beat(4'd0, 32'h33333333, 1'b1, 2'b10);
        tick();
        push_ar(32'h00000040, 4'd1, 4'd0);
        push_beat(1, 32'h44444444, 1'b1, 1'b1);
        req(1, 32'h00000040, 4'd0);
        wait_grant(1);
        send_beat(4'd0, 32'h44444444, 1'b1, 2'b00);
        tick();

        // 6: reset mid-burst, then a fresh request completes
        push_ar(32'hC0000000, 4'd0, 4'd3);
        push_beat(0, 32'h55550000, 1'b0, 1'b0);
        req(0, 32'hC0000000, 4'd3);
        wait_grant(0);
        send_beat(4'd0, 32'h55550000, 1'b0, 2'b00);
        resp_ready[0] = 1'b0;
        rid = 4'd0; rdata = 32'h55550001; rlast = 1'b0; rresp = 2'b00; rvalid = 1'b1;
        req(1, 32'h9FC00000, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", {arvalid, rready, req_ready, resp_valid, resp_last, resp_err}, '0);
        chk("mid_rst_araddr", araddr, 0);
        chk("mid_rst_data", resp_data, 0);
        rvalid = 1'b0;
        resp_ready[0] = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        push_ar(32'h1FC00000, 4'd1, 4'd1);
        push_beat(1, 32'h66660000, 1'b0, 1'b0);
        push_beat(1, 32'h66660001, 1'b1, 1'b0);
        wait_grant(1);
        send_beat(4'd1, 32'h66660000, 1'b0, 2'b00);
        send_beat(4'd1, 32'h66660001, 1'b1, 2'b00);
        tick();
        tick();

        chk("ar_q_drained", ar_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
